// File: rtl/trigger_arm_ctrl_if.sv
// Configuration bus between a host and trigger_arm_ctrl: compare-word writes,
// arm/disarm requests and the write-reject pulse returned by the controller.
interface trigger_arm_ctrl_if;
   logic        CfgValid;
   logic [2:0]  CfgAddr;
   logic [31:0] CfgData;
   logic        CfgArm;
   logic        CfgDisarm;
   logic        CfgReject;

   modport master (
      output CfgValid, CfgAddr, CfgData, CfgArm, CfgDisarm,
      input  CfgReject
   );

   modport slave (
      input  CfgValid, CfgAddr, CfgData, CfgArm, CfgDisarm,
      output CfgReject
   );
endinterface

// File: rtl/trigger_arm_ctrl.sv
// Arm/disarm controller in front of the RVVI ethernet trigger generator: holds the
// compare string, gates the receive stream on frame boundaries, conditions triggers.
module trigger_arm_ctrl #(
   parameter logic [159:0] DEFAULT_COMPARE = 160'd0,
   parameter int           HOLDOFF_W       = 16,
   parameter int           COUNT_W         = 8,
   parameter int           PULSE_LEN       = 10
) (
   input  logic                 clk,
   input  logic                 resetn,
   trigger_arm_ctrl_if.slave    cfg,
   input  logic [HOLDOFF_W-1:0] HoldoffCycles,
   input  logic [COUNT_W-1:0]   MaxTriggers,
   input  logic                 RvviAxiRvalid,
   input  logic                 RvviAxiRlast,
   output logic                 RvviAxiRvalidOut,
   output logic                 RvviAxiRlastOut,
   input  logic                 IlaTriggerIn,
   input  logic [31:0]          TriggerMessageIn,
   output logic [159:0]         CompareString,
   output logic                 IlaTriggerOut,
   output logic [31:0]          TriggerMessage,
   output logic                 MessageValid,
   output logic [COUNT_W-1:0]   TriggerCount,
   output logic                 Armed
);

   localparam int PULSE_W = $clog2(PULSE_LEN + 1);

   typedef enum logic [2:0] {
      S_DISARMED = 3'd0,
      S_ARM_PEND = 3'd1,
      S_ARMED    = 3'd2,
      S_HOLDOFF  = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t               state;
   state_t               state_next;
   logic                 in_frame;
   logic                 gate_open;
   logic                 gate_want;
   logic                 boundary;
   logic                 trig_prev;
   logic                 trig_accept;
   logic                 last_trigger;
   logic                 arm_clear;
   logic                 cfg_accept;
   logic                 msg_pend;
   logic [HOLDOFF_W-1:0] holdoff_cnt;
   logic [PULSE_W-1:0]   pulse_cnt;
   logic [COUNT_W:0]     count_inc;

   // A frame boundary is the only point where the gate or ARM_PEND may move on.
   assign boundary    = ~in_frame & ~RvviAxiRvalid;
   assign trig_accept = IlaTriggerIn & ~trig_prev & (state == S_ARMED);
   assign count_inc   = {1'b0, TriggerCount} + (COUNT_W + 1)'(1);
   assign last_trigger = (MaxTriggers != '0) && (count_inc >= {1'b0, MaxTriggers});

   assign RvviAxiRvalidOut = RvviAxiRvalid & gate_open;
   assign RvviAxiRlastOut  = RvviAxiRlast & gate_open;
   assign IlaTriggerOut    = (pulse_cnt != '0);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= S_DISARMED;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      if (cfg.CfgDisarm) begin
         state_next = S_DISARMED;
      end else begin
         unique case (state)
            S_DISARMED, S_DONE: begin
               if (cfg.CfgArm) state_next = S_ARM_PEND;
            end
            S_ARM_PEND: begin
               if (boundary) state_next = S_ARMED;
            end
            S_ARMED: begin
               if (trig_accept) state_next = last_trigger ? S_DONE : S_HOLDOFF;
            end
            S_HOLDOFF: begin
               if (holdoff_cnt == '0) state_next = S_ARMED;
            end
            default: state_next = S_DISARMED;
         endcase
      end
   end

   always_comb begin
      Armed      = (state == S_ARMED);
      gate_want  = (state == S_ARMED);
      arm_clear  = cfg.CfgArm & ~cfg.CfgDisarm &
                   ((state == S_DISARMED) || (state == S_DONE));
      cfg_accept = cfg.CfgValid & ~gate_open & (state != S_ARMED) &
                   (cfg.CfgAddr <= 3'd4);
   end

   // Stream framing and the boundary-synchronised gate.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         in_frame  <= 1'b0;
         gate_open <= 1'b0;
      end else begin
         if (RvviAxiRvalid) in_frame <= ~RvviAxiRlast;
         if (boundary) gate_open <= gate_want;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         trig_prev   <= 1'b0;
         holdoff_cnt <= '0;
         pulse_cnt   <= '0;
         TriggerCount <= '0;
      end else begin
         trig_prev <= IlaTriggerIn;

         if (trig_accept) begin
            holdoff_cnt <= HoldoffCycles;
         end else if ((state == S_HOLDOFF) && (holdoff_cnt != '0)) begin
            holdoff_cnt <= holdoff_cnt - HOLDOFF_W'(1);
         end

         // A fresh edge restarts the pulse even if one is still running.
         if (trig_accept) begin
            pulse_cnt <= PULSE_W'(PULSE_LEN);
         end else if (pulse_cnt != '0) begin
            pulse_cnt <= pulse_cnt - PULSE_W'(1);
         end

         if (arm_clear) begin
            TriggerCount <= '0;
         end else if (trig_accept && (TriggerCount != '1)) begin
            TriggerCount <= TriggerCount + COUNT_W'(1);
         end
      end
   end

   // Message is sampled one cycle after the accepted edge, published the cycle after.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         msg_pend       <= 1'b0;
         MessageValid   <= 1'b0;
         TriggerMessage <= '0;
      end else begin
         msg_pend     <= trig_accept;
         MessageValid <= msg_pend;
         if (msg_pend) TriggerMessage <= TriggerMessageIn;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         CompareString <= DEFAULT_COMPARE;
         cfg.CfgReject <= 1'b0;
      end else begin
         cfg.CfgReject <= cfg.CfgValid & ~cfg_accept;
         for (int i = 0; i < 5; i++) begin
            if (cfg_accept && (cfg.CfgAddr == 3'(i))) begin
               CompareString[32*i +: 32] <= cfg.CfgData;
            end
         end
      end
   end

endmodule

// File: tb/tb_trigger_arm_ctrl.sv
// Bench for trigger_arm_ctrl: config-write vector table, directed arm/trigger
// sequences and a random run, all checked against a cycle model kept here.
module tb_trigger_arm_ctrl;
   localparam logic [159:0] DEF = {32'hD0D0_0004, 32'hD0D0_0003, 32'hD0D0_0002,
                                   32'hD0D0_0001, 32'hD0D0_0000};
   localparam int P = 10;

   localparam int MD_IDLE = 0, MD_WAIT = 1, MD_LIVE = 2, MD_COOL = 3, MD_FIN = 4;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic [15:0]  HoldoffCycles = '0;
   logic [7:0]   MaxTriggers = '0;
   logic         rvalid = 1'b0;
   logic         rlast = 1'b0;
   logic         rvalid_out;
   logic         rlast_out;
   logic         ila_in = 1'b0;
   logic [31:0]  msg_in = '0;
   logic [159:0] cmp;
   logic         ila_out;
   logic [31:0]  msg;
   logic         mv;
   logic [7:0]   count;
   logic         armed;

   trigger_arm_ctrl_if cfg_if ();

   trigger_arm_ctrl #(
      .DEFAULT_COMPARE(DEF), .HOLDOFF_W(16), .COUNT_W(8), .PULSE_LEN(P)
   ) dut (
      .clk(clk), .resetn(resetn), .cfg(cfg_if),
      .HoldoffCycles(HoldoffCycles), .MaxTriggers(MaxTriggers),
      .RvviAxiRvalid(rvalid), .RvviAxiRlast(rlast),
      .RvviAxiRvalidOut(rvalid_out), .RvviAxiRlastOut(rlast_out),
      .IlaTriggerIn(ila_in), .TriggerMessageIn(msg_in),
      .CompareString(cmp), .IlaTriggerOut(ila_out),
      .TriggerMessage(msg), .MessageValid(mv),
      .TriggerCount(count), .Armed(armed)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Behavioural model state
   int          m_mode;
   bit          m_frame, m_gate, m_prev, m_msg_due, m_mv, m_rej;
   int          m_count, m_hold, m_pulse;
   logic [31:0] m_msg;
   logic [31:0] m_cmp [5];

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] data;
      logic        exp_rej;
      int          chk_idx;
      logic [31:0] exp_word;
   } cfg_vec_t;

   cfg_vec_t tbl [8];

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      logic [159:0] d;
      d = DEF;
      m_mode = MD_IDLE;
      m_frame = 0; m_gate = 0; m_prev = 0; m_msg_due = 0; m_mv = 0; m_rej = 0;
      m_count = 0; m_hold = 0; m_pulse = 0; m_msg = '0;
      for (int i = 0; i < 5; i++) m_cmp[i] = d[32*i +: 32];
   endtask

   task automatic compare_all();
      chk("rvalid_out", rvalid_out, rvalid & m_gate);
      chk("rlast_out", rlast_out, rlast & m_gate);
      chk("ila_out", ila_out, m_pulse > 0);
      chk("msg", msg, m_msg);
      chk("msg_valid", mv, m_mv);
      chk("count", count, 8'(m_count));
      chk("armed", armed, m_mode == MD_LIVE);
      chk("cfg_reject", cfg_if.CfgReject, m_rej);
      chk("compare", cmp, {m_cmp[4], m_cmp[3], m_cmp[2], m_cmp[1], m_cmp[0]});
   endtask

   task automatic model_advance();
      bit bnd, edge_acc, ok, reached;
      int old_mode, next_mode;
      if (!resetn) begin
         model_reset();
      end else begin
         old_mode  = m_mode;
         next_mode = m_mode;
         bnd       = !m_frame && !rvalid;
         edge_acc  = ila_in && !m_prev && (m_mode == MD_LIVE);
         reached   = (MaxTriggers != 0) && (m_count + 1 >= int'(MaxTriggers));

         ok = cfg_if.CfgValid && !m_gate && (m_mode != MD_LIVE) && (cfg_if.CfgAddr <= 3'd4);
         if (ok) m_cmp[int'(cfg_if.CfgAddr)] = cfg_if.CfgData;
         m_rej = cfg_if.CfgValid && !ok;

         m_mv = m_msg_due;
         if (m_msg_due) m_msg = msg_in;
         m_msg_due = edge_acc;

         if (edge_acc) m_pulse = P;
         else if (m_pulse > 0) m_pulse--;

         if (cfg_if.CfgDisarm) begin
            next_mode = MD_IDLE;
         end else begin
            case (m_mode)
               MD_IDLE, MD_FIN: if (cfg_if.CfgArm) begin next_mode = MD_WAIT; m_count = 0; end
               MD_WAIT: if (bnd) next_mode = MD_LIVE;
               MD_LIVE: if (edge_acc) begin
                  next_mode = reached ? MD_FIN : MD_COOL;
                  m_hold = int'(HoldoffCycles);
               end
               MD_COOL: if (m_hold == 0) next_mode = MD_LIVE; else m_hold--;
               default: next_mode = MD_IDLE;
            endcase
         end
         if (edge_acc) m_count = (m_count >= 255) ? 255 : m_count + 1;

         if (bnd) m_gate = (old_mode == MD_LIVE);
         if (rvalid) m_frame = !rlast;
         m_prev = ila_in;
         m_mode = next_mode;
      end
   endtask

   task automatic step();
      #1;
      compare_all();
      @(posedge clk);
      model_advance();
      @(negedge clk);
   endtask

   initial begin
      int hi, mvs;
      logic [31:0]  got;
      logic [159:0] c;

      cfg_if.CfgValid = 0; cfg_if.CfgAddr = '0; cfg_if.CfgData = '0;
      cfg_if.CfgArm = 0; cfg_if.CfgDisarm = 0;

      tbl[0] = '{3'd0, 32'h1111_1111, 1'b0, 0, 32'h1111_1111};
      tbl[1] = '{3'd1, 32'h2222_2222, 1'b0, 1, 32'h2222_2222};
      tbl[2] = '{3'd2, 32'h3333_3333, 1'b0, 2, 32'h3333_3333};
      tbl[3] = '{3'd3, 32'h4444_4444, 1'b0, 3, 32'h4444_4444};
      tbl[4] = '{3'd4, 32'h5555_5555, 1'b0, 4, 32'h5555_5555};
      tbl[5] = '{3'd5, 32'hDEAD_BEEF, 1'b1, 0, 32'h1111_1111};
      tbl[6] = '{3'd7, 32'hDEAD_BEEF, 1'b1, 4, 32'h5555_5555};
      tbl[7] = '{3'd2, 32'h0BAD_F00D, 1'b0, 2, 32'h0BAD_F00D};

      // Reset state
      resetn = 0;
      @(posedge clk); model_reset(); @(negedge clk);
      @(posedge clk); model_reset(); @(negedge clk);
      chk("rst_armed", armed, 1'b0);
      chk("rst_count", count, 8'd0);
      chk("rst_ila", ila_out, 1'b0);
      chk("rst_mv", mv, 1'b0);
      chk("rst_msg", msg, 32'd0);
      chk("rst_reject", cfg_if.CfgReject, 1'b0);
      chk("rst_compare", cmp, DEF);
      resetn = 1;

      // Config write table (disarmed, gate closed)
      for (int i = 0; i < 8; i++) begin
         cfg_if.CfgValid = 1; cfg_if.CfgAddr = tbl[i].addr; cfg_if.CfgData = tbl[i].data;
         step();
         c = cmp;
         chk("tbl_reject", cfg_if.CfgReject, tbl[i].exp_rej);
         chk("tbl_word", c[32*tbl[i].chk_idx +: 32], tbl[i].exp_word);
      end
      cfg_if.CfgValid = 0;
      step();
      chk("tbl_full", cmp, {32'h5555_5555, 32'h4444_4444, 32'h0BAD_F00D,
                            32'h2222_2222, 32'h1111_1111});

      // Arm on idle bus, then forward a frame
      cfg_if.CfgArm = 1; step(); cfg_if.CfgArm = 0;
      chk("arm_pend", armed, 1'b0);
      step();
      chk("arm_armed", armed, 1'b1);
      step();
      rvalid = 1; rlast = 0; #1;
      chk("fwd_beat0", rvalid_out, 1'b1);
      step(); step();
      rlast = 1; #1;
      chk("fwd_last", rlast_out, 1'b1);
      step();
      rvalid = 0; rlast = 0;

      // Arm requested mid-frame: nothing forwarded until the next frame
      cfg_if.CfgDisarm = 1; step(); cfg_if.CfgDisarm = 0;
      chk("disarm", armed, 1'b0);
      step();
      rvalid = 1; rlast = 0; step();
      cfg_if.CfgArm = 1; step(); cfg_if.CfgArm = 0;
      for (int i = 0; i < 3; i++) begin
         #1; chk("midframe_blocked", rvalid_out, 1'b0); step();
      end
      rlast = 1; #1; chk("midframe_last_blocked", rvalid_out, 1'b0); step();
      rvalid = 0; rlast = 0;
      step();
      chk("midframe_armed", armed, 1'b1);
      step();
      rvalid = 1; rlast = 1; #1;
      chk("next_frame_fwd", rvalid_out, 1'b1);
      step();
      rvalid = 0; rlast = 0;

      // Trigger held 10 cycles
      HoldoffCycles = 16'd20; MaxTriggers = 8'd0; msg_in = 32'hCAFE_0001;
      ila_in = 1; step();
      chk("trig_holdoff", armed, 1'b0);
      chk("trig_count", count, 8'd1);
      hi = 0; mvs = 0; got = '0;
      for (int i = 0; i < 30; i++) begin
         if (ila_out) hi++;
         if (mv) begin mvs++; got = msg; end
         if (i == 9) ila_in = 0;
         step();
      end
      chk("trig_pulse_len", 160'(hi), 160'(P));
      chk("trig_mv_pulses", 160'(mvs), 160'd1);
      chk("trig_message", got, 32'hCAFE_0001);

      // Max triggers = 2 with holdoff 5
      MaxTriggers = 8'd2; HoldoffCycles = 16'd5;
      cfg_if.CfgDisarm = 1; step(); cfg_if.CfgDisarm = 0;
      cfg_if.CfgArm = 1; step(); cfg_if.CfgArm = 0;
      step(); step();
      chk("max_armed", armed, 1'b1);
      chk("max_cleared", count, 8'd0);
      ila_in = 1; step(); ila_in = 0;
      for (int i = 0; i < 19; i++) step();
      ila_in = 1; step(); ila_in = 0;
      step(); step(); step();
      chk("max_count2", count, 8'd2);
      chk("max_done", armed, 1'b0);
      for (int i = 0; i < 20; i++) step();
      chk("max_done_stays", armed, 1'b0);
      ila_in = 1; step(); ila_in = 0;
      hi = 0; mvs = 0;
      for (int i = 0; i < 12; i++) begin
         if (ila_out) hi++;
         if (mv) mvs++;
         step();
      end
      chk("max_third_no_pulse", 160'(hi), 160'd0);
      chk("max_third_no_msg", 160'(mvs), 160'd0);
      chk("max_third_count", count, 8'd2);

      // Write refused while the gate is still open mid-frame
      cfg_if.CfgArm = 1; step(); cfg_if.CfgArm = 0;
      step(); step();
      rvalid = 1; rlast = 0; step();
      cfg_if.CfgDisarm = 1; step(); cfg_if.CfgDisarm = 0;
      #1; chk("gate_held_midframe", rvalid_out, 1'b1);
      cfg_if.CfgValid = 1; cfg_if.CfgAddr = 3'd1; cfg_if.CfgData = 32'h1234_5678;
      step(); cfg_if.CfgValid = 0;
      c = cmp;
      chk("gate_reject", cfg_if.CfgReject, 1'b1);
      chk("gate_word_kept", c[63:32], 32'h2222_2222);
      step();
      chk("gate_reject_pulse", cfg_if.CfgReject, 1'b0);
      rlast = 1; step();
      rvalid = 0; rlast = 0; step();

      // Arm and disarm together
      cfg_if.CfgArm = 1; cfg_if.CfgDisarm = 1; step();
      cfg_if.CfgArm = 0; cfg_if.CfgDisarm = 0;
      step(); chk("armdis_a", armed, 1'b0);
      step(); chk("armdis_b", armed, 1'b0);

      // Reset in the middle of a trigger pulse and a frame
      MaxTriggers = 8'd0; HoldoffCycles = 16'd2; msg_in = 32'h0000_0055;
      cfg_if.CfgArm = 1; step(); cfg_if.CfgArm = 0;
      step(); step();
      ila_in = 1; step(); ila_in = 0;
      rvalid = 1; rlast = 0;
      step(); step();
      chk("rstmid_pulse_on", ila_out, 1'b1);
      resetn = 0; step(); resetn = 1;
      chk("rstmid_ila", ila_out, 1'b0);
      chk("rstmid_count", count, 8'd0);
      chk("rstmid_mv", mv, 1'b0);
      chk("rstmid_msg", msg, 32'd0);
      chk("rstmid_armed", armed, 1'b0);
      chk("rstmid_compare", cmp, DEF);
      #1; chk("rstmid_gated", rvalid_out, 1'b0);
      step();
      rvalid = 0;

      // Random run against the model
      for (int n = 0; n < 4000; n++) begin
         resetn = ($urandom_range(0, 199) != 0);
         cfg_if.CfgValid = ($urandom_range(0, 9) == 0);
         cfg_if.CfgAddr = 3'($urandom_range(0, 7));
         cfg_if.CfgData = $urandom;
         cfg_if.CfgArm = ($urandom_range(0, 14) == 0);
         cfg_if.CfgDisarm = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 99) == 0) begin
            HoldoffCycles = 16'($urandom_range(0, 6));
            MaxTriggers = 8'($urandom_range(0, 3));
         end
         rvalid = ($urandom_range(0, 2) != 0);
         rlast = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 3) == 0) ila_in = ~ila_in;
         msg_in = $urandom;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
